mc_control: RTL and testbench

- Multi-cycle control FSM for the RV32I core datapath.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time, driving the PC/IR write enables, the ALU operand and operation selects, the writeback mux and the memory request handshake.
- Sits beside the register file, ALU and immediate generator. Decodes the opcode held in the instruction register.
- Supports loads, stores, I-type ALU, R-type, BEQ/BNE and LUI. Any other encoding traps.

---
 rtl/mc_if.sv | 36 +++
 rtl/mc_control.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_if.sv
// mc_if: bundles the instruction/flag inputs, memory handshake and datapath
// control lines between the multi-cycle controller (master) and the RV32I
// datapath/memory side (slave).
interface mc_if;
  logic [31:0] inst;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic        bus_err;
  logic [3:0]  state_dbg;

  modport master (
    input  inst, alu_zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
           illegal, bus_err, state_dbg
  );

  modport slave (
    output inst, alu_zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
           illegal, bus_err, state_dbg
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the RV32I datapath. Steps one
// instruction at a time through fetch, decode, execute, memory and writeback,
// with a bounded wait on every memory access and a sticky trap state.
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt / instret_cnt counters.
module mc_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  mc_if.master        bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    LUI_WB   = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // A wait that has already lasted MEM_TIMEOUT-1 cycles times out when the
  // current cycle also misses mem_ready.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       illegal_q, bus_err_q;
  logic       set_illegal, set_bus_err;
  logic       wait_hit;
  logic       br_taken;
  logic       br_legal;

  assign wait_hit = (wait_cnt == WAIT_LAST);
  assign br_legal = (bus.inst[14:13] == 2'b00);
  assign br_taken = (bus.inst[14:12] == 3'b000 &&  bus.alu_zero) ||
                    (bus.inst[14:12] == 3'b001 && !bus.alu_zero);

  // State register, wait counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  // Next-state and Moore control decode; everything held low during reset
  always_comb begin
    state_nx         = state;
    set_illegal      = 1'b0;
    set_bus_err      = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = 1'b0;
    bus.alu_src_a    = 2'b00;
    bus.alu_src_b    = 2'b00;
    bus.alu_op       = 2'b00;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = 2'b00;
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          // mem_ready is checked first so a late completion beats the timeout
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_nx     = DECODE;
          end else if (wait_hit) begin
            set_bus_err = 1'b1;
            state_nx    = TRAP;
          end
        end
        DECODE: begin
          // Old PC + immediate lands in ALUOut as the branch target
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b10;
          case (bus.inst[6:0])
            OP_LOAD, OP_STORE: state_nx = MEM_ADDR;
            OP_R:              state_nx = EXEC_R;
            OP_I:              state_nx = EXEC_I;
            OP_BRANCH:         state_nx = BRANCH;
            OP_LUI:            state_nx = LUI_WB;
            default: begin
              set_illegal = 1'b1;
              state_nx    = TRAP;
            end
          endcase
        end
        EXEC_R: begin
          bus.alu_src_a = 2'b01;
          bus.alu_op    = 2'b10;
          state_nx      = WB_ALU;
        end
        EXEC_I: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = 2'b10;
          state_nx      = WB_ALU;
        end
        MEM_ADDR: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          state_nx      = bus.inst[5] ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          if (bus.mem_ready) begin
            state_nx = WB_MEM;
          end else if (wait_hit) begin
            set_bus_err = 1'b1;
            state_nx    = TRAP;
          end
        end
        MEM_WR: begin
          bus.mem_req      = 1'b1;
          bus.mem_we       = 1'b1;
          bus.mem_addr_sel = 1'b1;
          if (bus.mem_ready) begin
            state_nx = FETCH;
          end else if (wait_hit) begin
            set_bus_err = 1'b1;
            state_nx    = TRAP;
          end
        end
        WB_ALU: begin
          bus.reg_write = 1'b1;
          state_nx      = FETCH;
        end
        WB_MEM: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = 2'b01;
          state_nx      = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a = 2'b01;
          bus.alu_op    = 2'b01;
          bus.pc_src    = 1'b1;
          if (br_legal) begin
            bus.pc_write = br_taken;
            state_nx     = FETCH;
          end else begin
            set_illegal = 1'b1;
            state_nx    = TRAP;
          end
        end
        LUI_WB: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = 2'b10;
          state_nx      = FETCH;
        end
        TRAP: begin
          state_nx = TRAP;
        end
        default: begin
          state_nx = TRAP;
        end
      endcase
    end
  end

  // Wait counter advances only while a request is stalled in the same state
  always_comb begin
    wait_cnt_nx = 8'd0;
    if (bus.mem_req && !bus.mem_ready && (state_nx == state))
      wait_cnt_nx = wait_cnt + 8'd1;
  end

  // Status outputs, forced low while reset is asserted
  always_comb begin
    bus.illegal   = illegal_q & ~reset;
    bus.bus_err   = bus_err_q & ~reset;
    bus.state_dbg = reset ? 4'd0 : state;
  end

`ifdef MC_PERF_CNT_EN
  logic retire;

  // Final cycle of each completed instruction
  always_comb begin
    retire = (state == WB_ALU) || (state == WB_MEM) || (state == LUI_WB) ||
             (state == MEM_WR && bus.mem_ready) ||
             (state == BRANCH && br_legal);
  end

  // Free-running cycle and retired-instruction counters, frozen in TRAP
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: random and directed instruction streams. For every
// instruction the bench plans the expected per-cycle state sequence and
// memory-ready pattern from the instruction class and chosen wait delays,
// then checks state and every control output each cycle.
module tb_mc_control;
  localparam int TO = 4;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3,
                 S_MEM_ADDR = 4, S_MEM_RD = 5, S_MEM_WR = 6, S_WB_ALU = 7,
                 S_WB_MEM = 8, S_BRANCH = 9, S_LUI_WB = 10, S_TRAP = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mc_if bus();
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  mc_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int st_q[$];
  bit rdy_q[$];
  bit ill_q[$];
  bit be_q[$];
  int trap_len = 3;
  logic [31:0] cur_inst;
  bit cur_az;

  logic [16:0] act;
  assign act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write,
                bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.reg_write, bus.wb_sel, bus.illegal, bus.bus_err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word required by the output table for a given state and inputs
  function automatic logic [16:0] exp_ctrl(int st, bit rdy, bit az, logic [2:0] f3,
                                           bit ill, bit be);
    logic req, we, asel, irw, pcw, pcs, rw;
    logic [1:0] a, b, op, wb;
    req = 0; we = 0; asel = 0; irw = 0; pcw = 0; pcs = 0; rw = 0;
    a = 2'b00; b = 2'b00; op = 2'b00; wb = 2'b00;
    case (st)
      S_FETCH:    begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   begin a = 2'b10; b = 2'b10; end
      S_EXEC_R:   begin a = 2'b01; op = 2'b10; end
      S_EXEC_I:   begin a = 2'b01; b = 2'b10; op = 2'b10; end
      S_MEM_ADDR: begin a = 2'b01; b = 2'b10; end
      S_MEM_RD:   begin req = 1; asel = 1; end
      S_MEM_WR:   begin req = 1; we = 1; asel = 1; end
      S_WB_ALU:   begin rw = 1; end
      S_WB_MEM:   begin rw = 1; wb = 2'b01; end
      S_BRANCH:   begin
        a = 2'b01; op = 2'b01; pcs = 1;
        pcw = (f3 == 3'b000 && az) || (f3 == 3'b001 && !az);
      end
      S_LUI_WB:   begin rw = 1; wb = 2'b10; end
      default:    ;
    endcase
    return {req, we, asel, irw, pcw, pcs, a, b, op, rw, wb, ill, be};
  endfunction

  task automatic push(input int st, input bit r);
    st_q.push_back(st);
    rdy_q.push_back(r);
    ill_q.push_back(1'b0);
    be_q.push_back(1'b0);
  endtask

  task automatic push_trap(input bit ill, input bit be);
    for (int i = 0; i < trap_len; i++) begin
      st_q.push_back(S_TRAP);
      rdy_q.push_back(1'($urandom_range(0, 1)));
      ill_q.push_back(ill);
      be_q.push_back(be);
    end
  endtask

  // A request state lasts d+1 cycles if d < TO, else times out after TO cycles
  task automatic plan_wait(input int st, input int d, output bit timed_out);
    if (d < TO) begin
      for (int i = 0; i < d; i++) push(st, 1'b0);
      push(st, 1'b1);
      timed_out = 1'b0;
    end else begin
      for (int i = 0; i < TO; i++) push(st, 1'b0);
      timed_out = 1'b1;
    end
  endtask

  task automatic plan_instr(input logic [31:0] ins, input int df, input int dm,
                            output bit trapped);
    bit to;
    logic [6:0] opc;
    opc = ins[6:0];
    st_q.delete(); rdy_q.delete(); ill_q.delete(); be_q.delete();
    trapped = 1'b0;
    plan_wait(S_FETCH, df, to);
    if (to) begin push_trap(1'b0, 1'b1); trapped = 1'b1; return; end
    push(S_DECODE, 1'($urandom_range(0, 1)));
    case (opc)
      7'b0110011: begin push(S_EXEC_R, 1'($urandom_range(0, 1))); push(S_WB_ALU, 1'($urandom_range(0, 1))); end
      7'b0010011: begin push(S_EXEC_I, 1'($urandom_range(0, 1))); push(S_WB_ALU, 1'($urandom_range(0, 1))); end
      7'b0000011: begin
        push(S_MEM_ADDR, 1'($urandom_range(0, 1)));
        plan_wait(S_MEM_RD, dm, to);
        if (to) begin push_trap(1'b0, 1'b1); trapped = 1'b1; end
        else push(S_WB_MEM, 1'($urandom_range(0, 1)));
      end
      7'b0100011: begin
        push(S_MEM_ADDR, 1'($urandom_range(0, 1)));
        plan_wait(S_MEM_WR, dm, to);
        if (to) begin push_trap(1'b0, 1'b1); trapped = 1'b1; end
      end
      7'b1100011: begin
        push(S_BRANCH, 1'($urandom_range(0, 1)));
        if (ins[14:12] != 3'b000 && ins[14:12] != 3'b001) begin
          push_trap(1'b1, 1'b0); trapped = 1'b1;
        end
      end
      7'b0110111: push(S_LUI_WB, 1'($urandom_range(0, 1)));
      default: begin push_trap(1'b1, 1'b0); trapped = 1'b1; end
    endcase
  endtask

  // Called at a negedge; drives each planned cycle, checks, moves to next negedge
  task automatic exec(input int limit);
    for (int k = 0; k < st_q.size() && k < limit; k++) begin
      bus.inst      = cur_inst;
      bus.alu_zero  = cur_az;
      bus.mem_ready = rdy_q[k];
      #1;
      chk($sformatf("state_c%0d", k), 32'(bus.state_dbg), 32'(st_q[k]));
      chk($sformatf("ctrl_s%0d", st_q[k]), 32'(act),
          32'(exp_ctrl(st_q[k], rdy_q[k], cur_az, cur_inst[14:12], ill_q[k], be_q[k])));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'($urandom_range(0, 1));
    #1;
    chk("rst_ctrl", 32'(act), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_ctrl2", 32'(act), 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] ins, input int df, input int dm, input bit az);
    bit trapped;
    cur_inst = ins;
    cur_az = az;
    plan_instr(ins, df, dm, trapped);
    exec(1000);
    if (trapped) do_reset();
  endtask

  function automatic bit legal_op(logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b0110111;
  endfunction

  function automatic int rnd_delay();
    if ($urandom_range(0, 15) == 0) return TO + int'($urandom_range(0, 1));
    return int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    logic [6:0] op;
    bit trapped;
    bus.inst = 32'd0;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed cases
    run_one(32'h00500093, 0, 0, 1'b0);   // addi
    run_one(32'h0000A103, 0, 3, 1'b0);   // lw, 3 wait cycles
    run_one(32'h00000463, 0, 0, 1'b1);   // beq taken
    run_one(32'h00001463, 0, 0, 1'b1);   // bne not taken
    run_one(32'h00001463, 0, 0, 1'b0);   // bne taken
    run_one(32'h123451B7, 0, 0, 1'b0);   // lui
    run_one(32'h0020A023, TO - 1, TO - 1, 1'b0); // sw, ready on the last allowed cycle
    trap_len = 10;
    run_one(32'hFFFFFFFF, 0, 0, 1'b0);   // illegal held 10 cycles
    trap_len = 3;
    run_one(32'h00500093, TO, 0, 1'b0);  // fetch timeout
    run_one(32'h0000A103, 0, TO, 1'b0);  // load timeout
    run_one(32'h00002463, 0, 0, 1'b0);   // branch with bad funct3

    // Reset in the middle of a stalled store
    cur_inst = 32'h0020A023;
    cur_az = 1'b0;
    plan_instr(cur_inst, 0, 100, trapped);
    exec(5);
    do_reset();
    run_one(32'h00500093, 1, 0, 1'b0);

`ifdef MC_PERF_CNT_EN
    do_reset();
    run_one(32'h00500093, 0, 0, 1'b0);
    run_one(32'h0000A103, 0, 0, 1'b0);
    run_one(32'h00000463, 0, 0, 1'b1);
    chk("instret_cnt", instret_cnt, 32'd3);
    chk("cycle_cnt", cycle_cnt, 32'd12);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 8:    ins = {r[31:7], 7'b0110011};
        1, 9:    ins = {r[31:7], 7'b0010011};
        2:       ins = {r[31:7], 7'b0000011};
        3:       ins = {r[31:7], 7'b0100011};
        4:       ins = {r[31:15], 2'b00, r[12:7], 7'b1100011};
        5:       ins = {r[31:7], 7'b0110111};
        6:       ins = {r[31:7], 7'b1100011};
        default: begin
          op = 7'($urandom_range(0, 127));
          while (legal_op(op)) op = 7'($urandom_range(0, 127));
          ins = {r[31:7], op};
        end
      endcase
      run_one(ins, rnd_delay(), rnd_delay(), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
